sub16_serial: RTL and testbench
===============================

// Module: sub16_serial
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor: diff = a - b - bin, one SLICE-bit
//  borrow-lookahead slice per clock, LSB slice first, borrow carried in a register.
//  Counterpart to the 16-bit carry-lookahead adder: shares its p/g group outputs (borrow form).
//  Sits behind valid/ready handshakes for area-constrained datapaths that tolerate latency.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of SLICE
//  SLICE  4   bits processed per cycle (width of the bla4 sub-module); N = WIDTH/SLICE
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  flush      in   1      synchronous abort; returns to IDLE, discards any operation
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (= state==IDLE && !flush)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid (= state==DONE)
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, mod 2^WIDTH
//  bout       out  1      borrow out of MSB (1 => a < b + bin, unsigned)
//  zero       out  1      diff == 0
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//  bp         out  1      group borrow-propagate: every bit p_i = ~(a_i ^ b_i), i.e. a == b
//  bg         out  1      group borrow-generate: a < b unsigned, independent of bin
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, slice count=0, borrow reg=0; out_valid=0,
//    diff=0, bout=0, zero=0, ovf=0, bp=0, bg=0. in_ready=1 once rst_n high (absent flush).
//  - Per-bit: g_i = ~a_i & b_i, p_i = ~(a_i ^ b_i), d_i = a_i ^ b_i ^ br_i,
//    br_{i+1} = g_i | (p_i & br_i). Slice group: P = &p, G = lookahead over g/p.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: on in_valid && in_ready edge capture a, b; borrow reg <= bin; cnt <= 0;
//          accumulators eq <= 1, lt <= 0; -> RUN.
//    RUN:  each edge computes slice cnt using borrow reg; writes diff[cnt*SLICE +: SLICE];
//          borrow reg <= slice borrow out; eq <= eq & P; lt <= G | (P & lt); cnt++.
//          After slice N-1 -> DONE; bout, zero, ovf, bp, bg registered on that same edge.
//    DONE: out_valid=1; all outputs held stable until out_valid && out_ready edge -> IDLE.
//  - Latency: acceptance edge E0; out_valid high after edge E_N (N=4 => 4 cycles).
//    Result handshake at earliest E_N+1; next acceptance earliest E_N+2.
//  - in_ready=0 in RUN and DONE; in_valid there is ignored (no queuing, no overwrite).
//  - Outputs retain last result after leaving DONE; diff updates slice-wise only in RUN
//    and is valid only while out_valid=1.
//  - out_ready outside DONE: ignored.
//  - flush (any state): next edge state=IDLE, out_valid=0, cnt=0; flush && in_valid
//    in IDLE: flush wins, no capture (in_ready already 0).
//  - rst_n asserted mid-RUN or in DONE: immediate return to reset values; result lost.
//  - N=1 (SLICE==WIDTH) legal: RUN lasts one cycle.
// STRUCTURE
//  - Shared package: state enum {IDLE,RUN,DONE}; localparam N and CNT_W = max(1,$clog2(N)).
//  - One sub-module: bla4 -- combinational SLICE-bit borrow-lookahead slice
//    (a, b, bin -> d, bout, P, G), instantiated once and reused each RUN cycle.
//  - Top: FSM, slice counter, operand/borrow/accumulator registers, operand slice muxes.
// TESTING
//  - a=0x1234, b=0x0235, bin=0 -> diff=0x0FFF, bout=0, zero=0, ovf=0, bp=0, bg=0; out_valid 4 cycles after accept.
//  - a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, bg=1, ovf=0; borrow ripples through all 4 slices.
//  - a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0; a=0xABCD, b=0xABCD, bin=0 -> diff=0, zero=1, bp=1, bg=0.
//  - a=b=0xABCD, bin=1 -> diff=0xFFFF, bout=1, bp=1, bg=0 (bg ignores bin).
//  - Hold out_ready=0 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; then release -> IDLE.
//  - flush at RUN cycle 2 -> IDLE next edge, out_valid never rises; rst_n low mid-RUN -> all outputs reset values at once.

Source files
------------

// File: rtl/sub16_serial_pkg.sv
// Shared types and sizing for the serial borrow-lookahead subtractor.
// Holds the FSM state encoding, default geometry and the counter-width helper.
package sub16_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  // A counter for a single slice still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int N     = WIDTH_DEF / SLICE_DEF;
  localparam int CNT_W = cnt_width(N);

endpackage

// File: rtl/sub16_serial_if.sv
// Operand/result handshake bundle for sub16_serial.
// The slave side is the subtractor, the master side is whoever feeds and drains it.
interface sub16_serial_if #(
  parameter int WIDTH = 16
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;
  logic             bp;
  logic             bg;

  modport master (
    output flush, in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf, bp, bg
  );

  modport slave (
    input  flush, in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf, bp, bg
  );

endinterface

// File: rtl/sub16_serial_bla4.sv
// Combinational SLICE-bit borrow-lookahead slice: d = a - b - bin.
// Also reports the slice's group borrow-propagate (a == b) and generate (a < b).
module bla4 #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout,
  output logic             grp_p,
  output logic             grp_g
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   br;
  logic [SLICE:0]   gacc;

  assign br[0]   = bin;
  assign gacc[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_bit
      assign g[gi]        = ~a[gi] & b[gi];
      assign p[gi]        = ~(a[gi] ^ b[gi]);
      assign d[gi]        = a[gi] ^ b[gi] ^ br[gi];
      assign br[gi+1]     = g[gi] | (p[gi] & br[gi]);
      // Group generate is the same recurrence seeded with no incoming borrow.
      assign gacc[gi+1]   = g[gi] | (p[gi] & gacc[gi]);
    end
  endgenerate

  assign bout  = br[SLICE];
  assign grp_p = &p;
  assign grp_g = gacc[SLICE];

endmodule

// File: rtl/sub16_serial.sv
// Serial subtractor: one borrow-lookahead slice per clock, LSB slice first,
// with the inter-slice borrow and the a==b / a<b accumulators held in registers.
module sub16_serial
  import sub16_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sub16_serial_if.slave bus
);

  // WIDTH must be a whole number of slices.
  localparam int             NS   = WIDTH / SLICE;
  localparam int             CW   = cnt_width(NS);
  localparam logic [CW-1:0]  LAST = CW'(NS - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             br_reg, eq_reg, lt_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg, zero_reg, ovf_reg, bp_reg, bg_reg;

  logic [SLICE-1:0] a_arr [NS];
  logic [SLICE-1:0] b_arr [NS];
  logic [SLICE-1:0] a_sl, b_sl, d_sl;
  logic             s_bout, s_p, s_g;
  logic [WIDTH-1:0] diff_next;
  logic             accept, last_slice;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_slice
      assign a_arr[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_arr[gi] = b_reg[gi*SLICE +: SLICE];
      // Only the slice under the counter changes; the rest keep their value.
      assign diff_next[gi*SLICE +: SLICE] = (cnt_reg == CW'(gi)) ? d_sl
                                                                  : diff_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_sl = a_arr[cnt_reg];
  assign b_sl = b_arr[cnt_reg];

  bla4 #(.SLICE(SLICE)) u_slice (
    .a     (a_sl),
    .b     (b_sl),
    .bin   (br_reg),
    .d     (d_sl),
    .bout  (s_bout),
    .grp_p (s_p),
    .grp_g (s_g)
  );

  assign accept     = (state_reg == IDLE) && bus.in_valid && !bus.flush;
  assign last_slice = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.in_valid)  state_next = RUN;
        RUN:     if (last_slice)    state_next = DONE;
        DONE:    if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE) && !bus.flush;
    bus.out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      br_reg   <= 1'b0;
      eq_reg   <= 1'b0;
      lt_reg   <= 1'b0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      bp_reg   <= 1'b0;
      bg_reg   <= 1'b0;
    end else if (bus.flush) begin
      cnt_reg <= '0;
    end else if (accept) begin
      a_reg   <= bus.a;
      b_reg   <= bus.b;
      br_reg  <= bus.bin;
      cnt_reg <= '0;
      eq_reg  <= 1'b1;
      lt_reg  <= 1'b0;
    end else if (state_reg == RUN) begin
      diff_reg <= diff_next;
      br_reg   <= s_bout;
      eq_reg   <= eq_reg & s_p;
      // A higher slice decides a<b unless it is equal, then the lower history stands.
      lt_reg   <= s_g | (s_p & lt_reg);
      cnt_reg  <= last_slice ? '0 : cnt_reg + 1'b1;
      if (last_slice) begin
        bout_reg <= s_bout;
        zero_reg <= (diff_next == '0);
        ovf_reg  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
        bp_reg   <= eq_reg & s_p;
        bg_reg   <= s_g | (s_p & lt_reg);
      end
    end
  end

  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.zero = zero_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.bp   = bp_reg;
  assign bus.bg   = bg_reg;

endmodule

// File: tb/tb_sub16_serial.sv
// Bench for sub16_serial: table vectors and random operands through a scoreboard,
// plus hand-written hold, flush and mid-run reset sequences.
module tb_sub16_serial;

  localparam int NSL = 4;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    logic        bp;
    logic        bg;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sub16_serial_if #(.WIDTH(16)) bus ();

  sub16_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  res_t sb [$];
  vec_t tbl [8];

  function automatic res_t mk(input logic [15:0] d, input logic bo, z, o, p, g);
    res_t r;
    r.diff = d; r.bout = bo; r.zero = z; r.ovf = o; r.bp = p; r.bg = g;
    return r;
  endfunction

  function automatic res_t model(input logic [15:0] a, b, input logic bin);
    logic [16:0] t;
    res_t r;
    t = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    r.diff = t[15:0];
    r.bout = t[16];
    r.zero = (t[15:0] == 16'd0);
    r.ovf  = (a[15] != b[15]) && (t[15] != a[15]);
    r.bp   = (a == b);
    r.bg   = (a < b);
    return r;
  endfunction

  function automatic res_t cur_out();
    return mk(bus.diff, bus.bout, bus.zero, bus.ovf, bus.bp, bus.bg);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [15:0] a, b, input logic bin, input res_t exp, input bit hold);
    int   cyc;
    bit   got;
    res_t r;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.bin = bin;
    bus.in_valid = 1'b1;
    bus.out_ready = !hold;
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back(exp);
    cyc = 0;
    got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc++;
      if (bus.out_valid) got = 1'b1;
      else if (cyc == 2) check("in_ready_run", {31'd0, bus.in_ready}, 32'd0);
    end
    r = sb.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout out_valid a=%h b=%h bin=%0d", a, b, bin);
    end else begin
      check("latency", cyc - 1, NSL);
      check("result", {11'd0, cur_out()}, {11'd0, r});
    end
    $display("txn a=%h b=%h bin=%0d diff=%h bout=%0d zero=%0d ovf=%0d bp=%0d bg=%0d exp_diff=%h",
             a, b, bin, bus.diff, bus.bout, bus.zero, bus.ovf, bus.bp, bus.bg, r.diff);
    if (!hold) @(posedge clk);
  endtask

  initial begin
    res_t held;
    bit   rose;
    logic [15:0] ra, rb;
    logic        rbin;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.bin = 1'b0;

    tbl[0] = '{16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 0, 0, 0, 0, 0)};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 0, 0, 1)};
    tbl[2] = '{16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 0, 1, 0, 0)};
    tbl[3] = '{16'hABCD, 16'hABCD, 1'b0, mk(16'h0000, 0, 1, 0, 1, 0)};
    tbl[4] = '{16'hABCD, 16'hABCD, 1'b1, mk(16'hFFFF, 1, 0, 0, 1, 0)};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 0, 1, 0, 1)};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, mk(16'hFFFE, 0, 0, 0, 0, 0)};
    tbl[7] = '{16'h0001, 16'h0000, 1'b1, mk(16'h0000, 0, 1, 0, 0, 0)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {10'd0, bus.out_valid, cur_out()}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].exp, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? ra : 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      run_txn(ra, rb, rbin, model(ra, rb, rbin), 1'b0);
    end

    // Consumer stalls in DONE while new operands are offered.
    run_txn(16'h1234, 16'h0235, 1'b0, mk(16'h0FFF, 0, 0, 0, 0, 0), 1'b1);
    held = cur_out();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bin = 1'b1;
      #1;
      check("hold_stable", {9'd0, bus.out_valid, bus.in_ready, cur_out()}, {9'd0, 1'b1, 1'b0, held});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    check("release_retain", {11'd0, cur_out()}, {11'd0, held});
    run_txn(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1, 0, 0, 0, 1), 1'b0);

    // Flush during the second RUN cycle.
    @(negedge clk);
    bus.a = 16'h5555; bus.b = 16'h1111; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    rose = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) rose = 1'b1;
    end
    check("flush_no_valid", {31'd0, rose}, 32'd0);

    // Flush together with in_valid in IDLE: nothing is captured.
    @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("flush_no_capture", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    run_txn(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 0, 1, 0, 0), 1'b0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0000; bus.bin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset", {10'd0, bus.out_valid, cur_out()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", {31'd0, bus.in_ready}, 32'd1);
    run_txn(16'hABCD, 16'hABCD, 1'b0, mk(16'h0000, 0, 1, 0, 1, 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
